vga_sync_rx: RTL and testbench
==============================

VGA_SYNC_RX -- requirements
Module: vga_sync_rx

Interface
REQ-001 Parameters (name, default, meaning): H_SYNC 96, HS pulse width in pixels; H_BP 48, horizontal back porch; H_ACT 640, active columns; H_TOTAL 800, pixels per line.
REQ-002 Parameters: V_SYNC 2, VS pulse width in lines; V_BP 33, vertical back porch; V_ACT 480, active rows; V_TOTAL 525, lines per frame; LOCK_FRAMES 2, consecutive good frames needed to lock.
REQ-003 One clock, clk; reset is asynchronous and active-low, rst_n.
REQ-004 clk  in  1  main clock (100 MHz).
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 pix_ce  in  1  pixel strobe, one clk wide, once per pixel (25 MHz rate); HS, VS and Din are sampled only on pix_ce.
REQ-007 HS, VS  in  1 each  VGA syncs, active-low; Din  in  12  RGB444 pixel data.
REQ-008 err_clr  in  1  synchronous clear of the sticky error flags.
REQ-009 col  out  10, row  out  9  recovered active coordinates; de  out  1  active-area flag; rgb  out  12  registered pixel.
REQ-010 frame_start  out  1  one-clk pulse at each frame boundary; locked  out  1  timing lock status.
REQ-011 line_err, frame_err  out  1 each  sticky error flags; h_meas  out  10, v_meas  out  10  last measured line and frame length.

Function
REQ-012 Edge detection compares the current pix_ce sample with the previous one; an HS fall is 1->0 on HS, a VS fall is 1->0 on VS.
REQ-013 h_cnt (10 bit) SHALL load 0 on an HS fall, else increment on pix_ce, saturating at 1023.
REQ-014 On an HS fall, h_meas <= h_cnt+1; if h_cnt+1 != H_TOTAL while locked, line_err <= 1.
REQ-015 v_cnt (10 bit) SHALL load 0 on a VS fall (this has priority over a coincident HS fall), else increment on each HS fall, saturating at 1023.
REQ-016 On a VS fall, v_meas <= v_cnt+1, and frame_start pulses for one clk in that same pix_ce cycle; frame_err <= 1 if v_cnt+1 != V_TOTAL while locked.
REQ-017 The FSM SHALL have the states SEARCH, TRAIN and LOCK; the reset state is SEARCH.
REQ-018 SEARCH: the first VS fall moves the FSM to TRAIN and sets good_cnt to 0.
REQ-019 TRAIN, on each VS fall: if v_cnt+1 == V_TOTAL and no bad line was seen since the last VS fall, good_cnt++; otherwise return to SEARCH. When good_cnt reaches LOCK_FRAMES, move to LOCK.
REQ-020 LOCK: any bad line length, bad frame length, or h_cnt reaching 1023 (loss of HS) SHALL move the FSM to SEARCH on that sample, and the error flag is set on the same sample.
REQ-021 locked = 1 only in LOCK.
REQ-022 The active area is H_SYNC+H_BP <= h_cnt < H_SYNC+H_BP+H_ACT and V_SYNC+V_BP <= v_cnt < V_SYNC+V_BP+V_ACT.
REQ-023 col = h_cnt-(H_SYNC+H_BP), row = v_cnt-(V_SYNC+V_BP), both truncated to port width.
REQ-024 de, col, row and rgb SHALL be registered: latency is 1 pix_ce after the sample that carries the pixel.
REQ-025 de is forced 0 unless locked; rgb = Din when de, else 0; col and row hold their last value when de = 0.
REQ-026 Outputs change only in pix_ce cycles; frame_start is the only pulse output.
REQ-027 err_clr clears line_err and frame_err; an error event in the same cycle wins, so the flag stays 1.
REQ-028 When pix_ce is held low, all state freezes.

Reset
REQ-029 rst_n low asynchronously sets: FSM = SEARCH; h_cnt, v_cnt, good_cnt = 0; col, row, de, rgb, frame_start, locked, line_err, frame_err = 0; h_meas, v_meas = 0; the previous-sample HS/VS registers = 1.
REQ-030 Reset asserted mid-frame SHALL require a full relock: the first VS fall, then LOCK_FRAMES good frames.

Configuration
REQ-031 Macro VGA_RX_CRC_EN, when defined, adds the outputs frame_crc (16 bit) and crc_valid (1 bit).
REQ-032 With VGA_RX_CRC_EN defined, the CRC is CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB first), updated by the 12-bit rgb each cycle de = 1.
REQ-033 With VGA_RX_CRC_EN defined, at the VS fall the CRC is latched to frame_crc and re-initialised; crc_valid pulses with frame_start only if locked held for the whole frame.
REQ-034 With VGA_RX_CRC_EN defined, frame_crc and crc_valid reset to 0.
REQ-035 Without VGA_RX_CRC_EN, the ports and logic are absent and all other behaviour is identical.

Verification
REQ-036 Standard 640x480 syncs from vga_ctrl timing, 3 frames -> locked rises at the 3rd VS fall; h_meas = 800, v_meas = 525; no errors.
REQ-037 Locked, then one line of 799 pixels -> line_err = 1 and locked = 0 at that HS fall; relock after 2 good frames; err_clr then clears line_err.
REQ-038 Locked, Din = pixel index -> first de = 1 at the sample after h_cnt = 144, v_cnt = 35 with col = 0, row = 0, rgb = Din; last active at col = 639, row = 479.
REQ-039 Locked, HS stuck high -> h_cnt saturates at 1023, locked falls, line_err = 1; de stays 0.
REQ-040 Reset pulse mid-frame -> all outputs 0 immediately; locked returns only after 3 VS falls; err_clr and an error in the same cycle -> flag stays 1.
REQ-041 VGA_RX_CRC_EN, Din constant 0x000 for a full locked frame -> frame_crc equals the model CRC of 307200 zero words; crc_valid = 1 with frame_start.

Source files
------------

// File: rtl/vga_sync_rx.sv
// VGA sync receiver: recovers pixel coordinates from HS/VS, measures line and
// frame length, and locks once the timing is stable. Define VGA_RX_CRC_EN for a per-frame CRC of the active pixels.
module vga_sync_rx #(
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int H_ACT       = 640,
    parameter int H_TOTAL     = 800,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int V_ACT       = 480,
    parameter int V_TOTAL     = 525,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_ce,
    input  logic        HS,
    input  logic        VS,
    input  logic [11:0] Din,
    input  logic        err_clr,
    output logic [9:0]  col,
    output logic [8:0]  row,
    output logic        de,
    output logic [11:0] rgb,
    output logic        frame_start,
    output logic        locked,
    output logic        line_err,
    output logic        frame_err,
    output logic [9:0]  h_meas,
    output logic [9:0]  v_meas
`ifdef VGA_RX_CRC_EN
    ,
    output logic [15:0] frame_crc,
    output logic        crc_valid
`endif
);

    localparam logic [1:0]  SEARCH   = 2'd0;
    localparam logic [1:0]  TRAIN    = 2'd1;
    localparam logic [1:0]  LOCK     = 2'd2;
    localparam logic [9:0]  CNT_MAX  = 10'h3FF;
    localparam logic [9:0]  H_TOT    = 10'(H_TOTAL);
    localparam logic [9:0]  V_TOT    = 10'(V_TOTAL);
    localparam logic [10:0] H_A0     = 11'(H_SYNC + H_BP);
    localparam logic [10:0] H_A1     = 11'(H_SYNC + H_BP + H_ACT);
    localparam logic [10:0] V_A0     = 11'(V_SYNC + V_BP);
    localparam logic [10:0] V_A1     = 11'(V_SYNC + V_BP + V_ACT);
    localparam logic [7:0]  LOCK_N   = 8'(LOCK_FRAMES);

    logic       hs_d, vs_d;
    logic [9:0] h_cnt, v_cnt;
    logic [1:0] st, st_nxt;
    logic [7:0] good_cnt, good_nxt, good_inc;
    logic       bad_seen;

    logic       hs_fall, vs_fall;
    logic [9:0] h_inc, v_inc, h_nxt, v_nxt;
    logic       line_bad, frame_bad, hs_lost;
    logic       act, de_nxt, lock_now, line_ev, frame_ev;
    logic [9:0] col_nxt;
    logic [8:0] row_nxt;

    always_comb begin
        hs_fall  = hs_d & ~HS;
        vs_fall  = vs_d & ~VS;
        h_inc    = h_cnt + 10'd1;
        v_inc    = v_cnt + 10'd1;
        good_inc = good_cnt + 8'd1;

        if (hs_fall)               h_nxt = '0;
        else if (h_cnt == CNT_MAX) h_nxt = h_cnt;
        else                       h_nxt = h_inc;

        // VS fall restarts the frame even when HS falls on the same sample
        if (vs_fall)                           v_nxt = '0;
        else if (hs_fall && v_cnt != CNT_MAX)  v_nxt = v_inc;
        else                                   v_nxt = v_cnt;

        line_bad  = hs_fall && (h_inc != H_TOT);
        frame_bad = vs_fall && (v_inc != V_TOT);
        hs_lost   = (h_nxt == CNT_MAX);

        st_nxt   = st;
        good_nxt = good_cnt;
        case (st)
            SEARCH: if (vs_fall) begin
                st_nxt   = TRAIN;
                good_nxt = '0;
            end
            TRAIN: if (vs_fall) begin
                // the coincident HS fall closes the last line of the frame
                if (!frame_bad && !bad_seen && !line_bad) begin
                    good_nxt = good_inc;
                    if (good_inc >= LOCK_N) st_nxt = LOCK;
                end else begin
                    st_nxt   = SEARCH;
                    good_nxt = '0;
                end
            end
            LOCK: if (line_bad || frame_bad || hs_lost) begin
                st_nxt   = SEARCH;
                good_nxt = '0;
            end
            default: begin
                st_nxt   = SEARCH;
                good_nxt = '0;
            end
        endcase

        lock_now = (st == LOCK);
        line_ev  = lock_now && (line_bad || hs_lost);
        frame_ev = lock_now && frame_bad;

        act = ({1'b0, h_nxt} >= H_A0) && ({1'b0, h_nxt} < H_A1) &&
              ({1'b0, v_nxt} >= V_A0) && ({1'b0, v_nxt} < V_A1);
        de_nxt  = act && (st_nxt == LOCK);
        col_nxt = 10'({1'b0, h_nxt} - H_A0);
        row_nxt = 9'({1'b0, v_nxt} - V_A0);
    end

    assign locked = (st == LOCK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_d        <= 1'b1;
            vs_d        <= 1'b1;
            h_cnt       <= '0;
            v_cnt       <= '0;
            st          <= SEARCH;
            good_cnt    <= '0;
            bad_seen    <= 1'b0;
            col         <= '0;
            row         <= '0;
            de          <= 1'b0;
            rgb         <= '0;
            frame_start <= 1'b0;
            line_err    <= 1'b0;
            frame_err   <= 1'b0;
            h_meas      <= '0;
            v_meas      <= '0;
        end else begin
            frame_start <= pix_ce & vs_fall;
            if (pix_ce) begin
                hs_d     <= HS;
                vs_d     <= VS;
                h_cnt    <= h_nxt;
                v_cnt    <= v_nxt;
                st       <= st_nxt;
                good_cnt <= good_nxt;
                if (vs_fall)       bad_seen <= 1'b0;
                else if (line_bad) bad_seen <= 1'b1;
                if (hs_fall) h_meas <= h_inc;
                if (vs_fall) v_meas <= v_inc;
                // a new error beats a simultaneous clear
                line_err  <= line_ev  | (line_err  & ~err_clr);
                frame_err <= frame_ev | (frame_err & ~err_clr);
                de  <= de_nxt;
                rgb <= de_nxt ? Din : 12'd0;
                if (de_nxt) begin
                    col <= col_nxt;
                    row <= row_nxt;
                end
            end
        end
    end

`ifdef VGA_RX_CRC_EN
    // CRC-16-CCITT, 12 data bits per step, MSB first
    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [11:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 11; i >= 0; i--)
            r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
        return r;
    endfunction

    logic [15:0] crc, crc_cur;
    logic        frame_ok;

    assign crc_cur = de ? crc_upd(crc, rgb) : crc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc       <= 16'hFFFF;
            frame_crc <= '0;
            crc_valid <= 1'b0;
            frame_ok  <= 1'b0;
        end else begin
            crc_valid <= pix_ce & vs_fall & frame_ok & (st_nxt == LOCK);
            if (pix_ce) begin
                if (vs_fall) begin
                    frame_crc <= crc_cur;
                    crc       <= 16'hFFFF;
                    frame_ok  <= (st_nxt == LOCK);
                end else begin
                    crc <= crc_cur;
                    if (st_nxt != LOCK) frame_ok <= 1'b0;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync_rx.sv
// Directed bench for vga_sync_rx on a shrunken timing (20x10 total, 8x4 active)
// so every scenario fits in a few thousand pixels.
module tb_vga_sync_rx;

    localparam int HSW = 4, HBP = 4, HAC = 8, HT = 20;
    localparam int VSW = 2, VBP = 2, VAC = 4, VT = 10;

    logic        clk, rst_n, pix_ce, HS, VS, err_clr;
    logic [11:0] Din;
    logic [9:0]  col;
    logic [8:0]  row;
    logic        de, frame_start, locked, line_err, frame_err;
    logic [11:0] rgb;
    logic [9:0]  h_meas, v_meas;
`ifdef VGA_RX_CRC_EN
    logic [15:0] frame_crc;
    logic        crc_valid;
`endif

    vga_sync_rx #(
        .H_SYNC(HSW), .H_BP(HBP), .H_ACT(HAC), .H_TOTAL(HT),
        .V_SYNC(VSW), .V_BP(VBP), .V_ACT(VAC), .V_TOTAL(VT), .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .HS(HS), .VS(VS), .Din(Din),
        .err_clr(err_clr), .col(col), .row(row), .de(de), .rgb(rgb),
        .frame_start(frame_start), .locked(locked), .line_err(line_err),
        .frame_err(frame_err), .h_meas(h_meas), .v_meas(v_meas)
`ifdef VGA_RX_CRC_EN
        , .frame_crc(frame_crc), .crc_valid(crc_valid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int cur_vl, cur_p;
    int de_cnt, rgb_bad, f_pos, l_pos;
    bit de_seen, din_zero, fs_q, fs_w, cv_q, cv0;
    logic [9:0]  f_col, l_col, hm0, vm0;
    logic [8:0]  f_row, l_row;
    logic [11:0] f_rgb, l_rgb;
    logic        lk0, le0, fe0, fs0, f_lk0, f_fs0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] din_of(input int vl, input int p);
        if (din_zero) return 12'd0;
        return 12'((vl << 5) | p);
    endfunction

    task automatic clr_cap();
        de_cnt = 0; rgb_bad = 0; de_seen = 0;
    endtask

    // one pixel: a single-clk pix_ce followed by one idle clk
    task automatic pix(input logic hs, input logic vs, input logic [11:0] d);
        HS = hs; VS = vs; Din = d; pix_ce = 1'b1;
        @(posedge clk); #1;
        pix_ce = 1'b0;
        fs_q = frame_start;
`ifdef VGA_RX_CRC_EN
        cv_q = crc_valid;
`else
        cv_q = 1'b0;
`endif
        if (de) begin
            de_cnt++;
            if (!de_seen) begin
                de_seen = 1; f_col = col; f_row = row; f_rgb = rgb; f_pos = cur_vl * 100 + cur_p;
            end
            l_col = col; l_row = row; l_rgb = rgb; l_pos = cur_vl * 100 + cur_p;
        end else if (rgb != 12'd0) rgb_bad++;
        @(posedge clk); #1;
        if (frame_start) fs_w = 1;
    endtask

    task automatic send_line(input int vl, input int len, input bit hs_on, input bit clr0);
        for (int p = 0; p < len; p++) begin
            cur_vl = vl; cur_p = p;
            err_clr = clr0 && (p == 0);
            pix(hs_on ? (p >= HSW) : 1'b1, (vl >= VSW), din_of(vl, p));
            if (p == 0) begin
                lk0 = locked; le0 = line_err; fe0 = frame_err;
                hm0 = h_meas; vm0 = v_meas; fs0 = fs_q; cv0 = cv_q;
            end
        end
        err_clr = 1'b0;
    endtask

    task automatic send_frame(input int nl);
        for (int vl = 0; vl < nl; vl++) begin
            send_line(vl, HT, 1'b1, 1'b0);
            if (vl == 0) begin f_lk0 = lk0; f_fs0 = fs0; end
        end
    endtask

`ifdef VGA_RX_CRC_EN
    function automatic logic [15:0] crc_model(input int n);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int k = 0; k < n; k++)
            for (int i = 0; i < 12; i++)
                c = {c[14:0], 1'b0} ^ (c[15] ? 16'h1021 : 16'h0000);
        return c;
    endfunction
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; pix_ce = 1'b0; HS = 1'b1; VS = 1'b1; Din = '0; err_clr = 1'b0;
        din_zero = 0; fs_w = 0;
        clr_cap();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_locked", locked, 0);
        chk("rst_de", de, 0);
        chk("rst_hmeas", h_meas, 0);
        chk("rst_vmeas", v_meas, 0);
        chk("rst_errs", {line_err, frame_err, frame_start}, 0);
        chk("rst_colrow_rgb", {col, row, rgb}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // acquisition: lock on the 3rd VS fall
        for (int k = 0; k < 5; k++) pix(1'b1, 1'b1, 12'd0);
        send_frame(VT);
        chk("f1_locked", f_lk0, 0);
        chk("f1_fs", f_fs0, 1);
        send_frame(VT);
        chk("f2_locked", f_lk0, 0);
        clr_cap();
        send_frame(VT);
        chk("f3_locked", f_lk0, 1);
        chk("f3_fs", f_fs0, 1);
        chk("h_meas", h_meas, HT);
        chk("v_meas", v_meas, VT);
        chk("no_errs", {line_err, frame_err}, 0);
        chk("first_de_pos", f_pos, (VSW + VBP) * 100 + HSW + HBP);
        chk("first_col", f_col, 0);
        chk("first_row", f_row, 0);
        chk("first_rgb", f_rgb, din_of(4, 8));
        chk("last_de_pos", l_pos, 715);
        chk("last_col", l_col, HAC - 1);
        chk("last_row", l_row, VAC - 1);
        chk("last_rgb", l_rgb, din_of(7, 15));
        chk("de_count", de_cnt, HAC * VAC);
        chk("rgb_zero_off_de", rgb_bad, 0);

        // short line while locked
        clr_cap();
        for (int vl = 0; vl < 5; vl++) send_line(vl, HT, 1'b1, 1'b0);
        send_line(5, HT - 1, 1'b1, 1'b0);
        chk("lock_before_short", locked, 1);
        send_line(6, HT, 1'b1, 1'b0);
        chk("short_unlock", lk0, 0);
        chk("short_line_err", le0, 1);
        chk("short_hmeas", hm0, HT - 1);
        for (int vl = 7; vl < VT; vl++) send_line(vl, HT, 1'b1, 1'b0);
        chk("short_de_count", de_cnt, 2 * HAC);
        send_frame(VT);
        send_frame(VT);
        chk("relock_early", f_lk0, 0);
        send_frame(VT);
        chk("relock", f_lk0, 1);
        chk("line_err_sticky", line_err, 1);
        for (int vl = 0; vl < 4; vl++) send_line(vl, HT, 1'b1, 1'b0);
        send_line(4, HT, 1'b1, 1'b1);
        chk("err_clr_line", le0, 0);
        chk("err_clr_locked", lk0, 1);

        // HS stuck high: counter saturates at 1023
        send_line(5, HT, 1'b1, 1'b0);
        clr_cap();
        cur_vl = 6;
        for (int k = 1; k <= 1003; k++) begin cur_p = k; pix(1'b1, 1'b1, 12'd5); end
        chk("stuck_pre_lock", locked, 1);
        chk("stuck_pre_err", line_err, 0);
        pix(1'b1, 1'b1, 12'd5);
        chk("stuck_unlock", locked, 0);
        chk("stuck_line_err", line_err, 1);
        for (int k = 0; k < 20; k++) pix(1'b1, 1'b1, 12'd5);
        send_line(7, HT, 1'b1, 1'b0);
        chk("stuck_hmeas_sat", hm0, 0);
        chk("stuck_de", de_cnt, 0);
        send_line(8, HT, 1'b1, 1'b0);
        send_line(9, HT, 1'b1, 1'b0);

        // reset mid-frame, then full relock
        send_frame(VT);
        send_frame(VT);
        for (int vl = 0; vl < 6; vl++) begin
            send_line(vl, HT, 1'b1, 1'b0);
            if (vl == 0) chk("lock_after_stuck", lk0, 1);
        end
        rst_n = 1'b0;
        #2;
        chk("mid_rst_locked", locked, 0);
        chk("mid_rst_colrow", {col, row}, 0);
        chk("mid_rst_meas", {h_meas, v_meas}, 0);
        chk("mid_rst_flags", {de, rgb, line_err, frame_err}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int vl = 6; vl < VT; vl++) send_line(vl, HT, 1'b1, 1'b0);
        send_frame(VT);
        chk("rst_relock_1", f_lk0, 0);
        send_frame(VT);
        chk("rst_relock_2", f_lk0, 0);
        send_line(0, HT, 1'b1, 1'b0);
        chk("rst_relock_3", lk0, 1);
        send_line(1, HT, 1'b1, 1'b0);
        send_line(2, HT - 1, 1'b1, 1'b0);
        send_line(3, HT, 1'b1, 1'b1);
        chk("err_beats_clr", le0, 1);
        chk("err_beats_clr_lock", lk0, 0);
        for (int vl = 4; vl < VT; vl++) send_line(vl, HT, 1'b1, 1'b0);

        // short frame while locked
        send_frame(VT);
        send_frame(VT);
        send_frame(VT - 1);
        chk("pre_short_frame_lock", f_lk0, 1);
        send_line(0, HT, 1'b1, 1'b0);
        chk("short_frame_unlock", lk0, 0);
        chk("frame_err", fe0, 1);
        chk("short_vmeas", vm0, VT - 1);
        send_line(1, HT, 1'b1, 1'b1);
        chk("frame_err_clr", fe0, 0);
        chk("line_err_clr", le0, 0);
        for (int vl = 2; vl < VT; vl++) send_line(vl, HT, 1'b1, 1'b0);

`ifdef VGA_RX_CRC_EN
        send_frame(VT);
        send_frame(VT);
        din_zero = 1;
        send_frame(VT);
        chk("crc_lock", f_lk0, 1);
        chk("crc_valid_partial", cv0, 0);
        send_line(0, HT, 1'b1, 1'b0);
        chk("crc_valid", cv0, 1);
        chk("frame_crc", frame_crc, crc_model(HAC * VAC));
        din_zero = 0;
`endif

        chk("fs_one_clk", fs_w, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
